fft64_sdf_ctrl: RTL and testbench

Sequencer for the 6-stage radix-2 single-delay-feedback (SDF) 64-point FFT pipeline.
- Stages 0..5 have feedback FIFO depths D_k = 32,16,8,4,2,1.
- Generates the global advance enable (drives every PE's FIFO w_en/r_en and output registers), the per-stage butterfly selects, and the twiddle exponents for the 5 inter-stage multipliers.
- Frames the output stream (valid/last).
- Accepts a streaming input with a valid/ready handshake and drains the pipeline after the last frame.

---
 rtl/fft64_sdf_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fft64_sdf_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_sdf_ctrl.sv
// Sequencer for a 6-stage radix-2 SDF 64-point FFT: advance enable, butterfly selects, twiddles, output framing.
// Optional macro BITREV_ADDR_EN builds the bit-reversed natural-order output index.
module fft64_sdf_ctrl #(
    parameter int MULT_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        adv,
    output logic        zero_in,
    output logic [5:0]  sel,
    output logic [29:0] tw_exp,
    output logic        out_valid,
    output logic        out_last,
    output logic [5:0]  out_idx,
    output logic        busy,
    input  logic        err_clr,
    output logic        err_underrun
);

    localparam int TOTAL_LAT = 69 + 5 * MULT_LAT;
    // out_act is loaded one advance before the final register receives sample 0,
    // so the registered out_valid lands exactly on the first output sample.
    localparam int         ACT_POS    = TOTAL_LAT - 2;
    localparam logic [5:0] ACT_CNT    = 6'(ACT_POS % 64);
    localparam bit         TAG_SEL    = 1'(ACT_POS / 64);
    localparam logic [6:0] DRAIN_LOAD = 7'(TOTAL_LAT - 1);

    // Advance offset at which stage k sees sample 0 of a frame.
    function automatic int stage_l(input int k);
        int l;
        l = 0;
        for (int i = 0; i < k; i++) begin
            l += (32 >> i) + 1 + MULT_LAT;
        end
        return l;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] cnt_reg;
    logic [6:0] drain_cnt_reg;
    logic [1:0] tag_reg;
    logic       out_act_reg;
    logic       out_valid_reg;
    logic       out_last_reg;
    logic       err_reg;
    logic       accept;
    logic       err_set;
    logic       to_idle;
    logic       cnt_zero;

    assign cnt_zero = (cnt_reg == 6'd0);

    always_comb begin
        state_next = state_reg;
        adv        = 1'b0;
        in_ready   = 1'b1;
        zero_in    = 1'b0;
        accept     = 1'b0;
        err_set    = 1'b0;
        to_idle    = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = in_valid;
                adv    = in_valid;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                adv    = 1'b1;
                accept = in_valid;
                if (!in_valid) begin
                    zero_in = 1'b1;
                    if (cnt_zero) begin
                        state_next = DRAIN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            DRAIN: begin
                adv      = 1'b1;
                in_ready = cnt_zero;
                accept   = in_valid & cnt_zero;
                zero_in  = ~(in_valid & cnt_zero);
                if (in_valid && cnt_zero) begin
                    state_next = RUN;
                end else if (drain_cnt_reg == 7'd0) begin
                    state_next = IDLE;
                    to_idle    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 6'd0;
            drain_cnt_reg <= 7'd0;
            tag_reg       <= 2'b00;
            out_act_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (adv) begin
                // Returning to IDLE realigns the frame counter for the next session.
                cnt_reg <= to_idle ? 6'd0 : cnt_reg + 6'd1;
                if (state_reg == RUN && state_next == DRAIN) begin
                    drain_cnt_reg <= DRAIN_LOAD;
                end else if (state_reg == DRAIN && drain_cnt_reg != 7'd0) begin
                    drain_cnt_reg <= drain_cnt_reg - 7'd1;
                end
                if (to_idle) begin
                    tag_reg <= 2'b00;
                end else if (cnt_zero) begin
                    tag_reg <= {tag_reg[0], accept};
                end
                if (to_idle) begin
                    out_act_reg <= 1'b0;
                end else if (cnt_reg == ACT_CNT) begin
                    out_act_reg <= tag_reg[TAG_SEL];
                end
            end
            out_valid_reg <= adv & out_act_reg;
            out_last_reg  <= adv & out_act_reg & (cnt_reg == ACT_CNT);
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    genvar gi;

    for (gi = 0; gi < 6; gi++) begin : g_sel
        localparam logic [5:0] LK       = 6'(stage_l(gi) % 64);
        localparam logic [5:0] SEL_MASK = 6'(1 << (5 - gi));
        logic [5:0] rel;
        assign rel     = cnt_reg - LK;
        assign sel[gi] = adv & (|(rel & SEL_MASK));
    end

    // Second half of each 2*D_k block gets exponent (j-D_k)<<k.
    for (gi = 0; gi < 5; gi++) begin : g_tw
        localparam int         DK       = 32 >> gi;
        localparam logic [5:0] OK       = 6'((stage_l(gi) + DK + 1) % 64);
        localparam logic [5:0] HI_MASK  = 6'(DK);
        localparam logic [5:0] LO_MASK  = 6'(DK - 1);
        logic [5:0] m;
        assign m = cnt_reg - OK;
        assign tw_exp[6*gi+5:6*gi] = (adv && (|(m & HI_MASK))) ? ((m & LO_MASK) << gi) : 6'd0;
    end

`ifdef BITREV_ADDR_EN
    localparam logic [5:0] IDX_OFS = 6'((TOTAL_LAT - 1) % 64);
    logic [5:0] idx_next;
    logic [5:0] idx_rev;
    logic [5:0] out_idx_reg;

    assign idx_next = cnt_reg - IDX_OFS;
    for (gi = 0; gi < 6; gi++) begin : g_rev
        assign idx_rev[gi] = idx_next[5-gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_reg <= 6'd0;
        end else if (adv) begin
            out_idx_reg <= idx_rev;
        end
    end
    assign out_idx = out_idx_reg;
`else
    assign out_idx = 6'd0;
`endif

    assign out_valid    = out_valid_reg;
    assign out_last     = out_last_reg;
    assign busy         = (state_reg != IDLE);
    assign err_underrun = err_reg;

endmodule

// File: tb/tb_fft64_sdf_ctrl.sv
// Bench for fft64_sdf_ctrl: frame-level behavioural model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_fft64_sdf_ctrl;

    localparam int T0 = 69;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic        in_ready, adv, zero_in, out_valid, out_last, busy, err_underrun;
    logic [5:0]  sel, out_idx;
    logic [29:0] tw_exp;

    logic        in_ready_1, adv_1, zero_in_1, out_valid_1, out_last_1, busy_1, err_underrun_1;
    logic [5:0]  sel_1, out_idx_1;
    logic [29:0] tw_exp_1;

    fft64_sdf_ctrl #(.MULT_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .adv(adv),
        .zero_in(zero_in), .sel(sel), .tw_exp(tw_exp), .out_valid(out_valid),
        .out_last(out_last), .out_idx(out_idx), .busy(busy), .err_clr(err_clr),
        .err_underrun(err_underrun)
    );

    fft64_sdf_ctrl #(.MULT_LAT(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1), .adv(adv_1),
        .zero_in(zero_in_1), .sel(sel_1), .tw_exp(tw_exp_1), .out_valid(out_valid_1),
        .out_last(out_last_1), .out_idx(out_idx_1), .busy(busy_1), .err_clr(err_clr),
        .err_underrun(err_underrun_1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bitrev6(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 6; b++) begin
            if (v[b]) r |= (1 << (5 - b));
        end
        return r;
    endfunction

    function automatic int l_of(input int k);
        int l;
        l = 0;
        for (int i = 0; i < k; i++) l += (32 >> i) + 1;
        return l;
    endfunction

    function automatic int mod64(input int v);
        return ((v % 64) + 64) % 64;
    endfunction

    // Model: a session is a run of advances numbered p; frames start at p multiples of 64.
    bit m_active = 0;
    int m_p = 0;
    int m_last = 0;
    int starts[$];
    bit exp_ov = 0, exp_ol = 0, exp_err = 0;
    int exp_idx = 0;

    int ov_total = 0, last_total = 0, rise_total = 0, rise_cyc = 0;
    int ov1_total = 0, rise1_cyc = 0;
    bit prev_ov = 0, prev_ov1 = 0;

    always @(negedge clk) begin
        int q, n, m, j, d, dk;
        bit e_ready, e_adv, e_zero, e_busy, acc, uset, bnd, infr, found;
        int e_sel, e_tw, nd;
        if (!rst_n) begin
            m_active = 0; m_p = 0; m_last = 0; starts.delete();
            exp_ov = 0; exp_ol = 0; exp_err = 0; exp_idx = 0;
        end
        check("out_valid", int'(out_valid), int'(exp_ov));
        check("out_last", int'(out_last), int'(exp_ol));
`ifdef BITREV_ADDR_EN
        if (exp_ov) check("out_idx", int'(out_idx), exp_idx);
`else
        check("out_idx", int'(out_idx), 0);
`endif
        check("err_underrun", int'(err_underrun), int'(exp_err));

        bnd = 0; uset = 0;
        if (!m_active) begin
            q = 0; e_ready = 1; e_adv = in_valid; e_zero = 0; e_busy = 0; acc = in_valid;
        end else begin
            q = m_p;
            bnd = (m_p % 64 == 0);
            infr = (m_p < m_last + 64);
            e_ready = bnd || infr;
            e_adv = 1;
            acc = in_valid && e_ready;
            e_zero = !acc;
            e_busy = 1;
            uset = infr && !bnd && !in_valid;
        end
        e_sel = 0; e_tw = 0;
        if (e_adv) begin
            for (int k = 0; k < 6; k++) begin
                dk = 32 >> k;
                n = mod64(q - l_of(k));
                if (n % (2 * dk) >= dk) e_sel |= (1 << k);
            end
            for (int k = 0; k < 5; k++) begin
                dk = 32 >> k;
                m = mod64(q - (l_of(k) + dk + 1));
                j = m % (2 * dk);
                if (j >= dk) e_tw |= ((j - dk) * (1 << k)) << (6 * k);
            end
        end
        check("adv", int'(adv), int'(e_adv));
        check("in_ready", int'(in_ready), int'(e_ready));
        check("zero_in", int'(zero_in), int'(e_zero));
        check("busy", int'(busy), int'(e_busy));
        check("sel", int'(sel), e_sel);
        check("tw_exp", int'(tw_exp), e_tw);

        if (out_valid) ov_total++;
        if (out_last) last_total++;
        if (out_valid && !prev_ov) begin rise_total++; rise_cyc = cyc; end
        prev_ov = out_valid;
        if (out_valid_1) ov1_total++;
        if (out_valid_1 && !prev_ov1) rise1_cyc = cyc;
        prev_ov1 = out_valid_1;

        if (rst_n) begin
            found = 0; nd = 0;
            foreach (starts[i]) begin
                d = q + 1 - T0 - starts[i];
                if (d >= 0 && d <= 63) begin found = 1; nd = d; end
            end
            exp_ov = e_adv && found;
            exp_ol = exp_ov && (nd == 63);
            exp_idx = bitrev6(nd);
            if (uset) exp_err = 1;
            else if (err_clr) exp_err = 0;
            if (!m_active) begin
                if (in_valid) begin
                    m_active = 1; m_p = 1; m_last = 0; starts.push_back(0);
                end
            end else begin
                if (bnd && acc) begin starts.push_back(m_p); m_last = m_p; end
                if (m_p == m_last + 64 + T0) begin
                    m_active = 0; m_p = 0; starts.delete();
                end else begin
                    m_p++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic c);
        @(posedge clk);
        #1;
        in_valid = v;
        err_clr = c;
        #2;
    endtask

    task automatic settle();
        for (int i = 0; i < 400; i++) begin
            if (!busy && !busy_1) break;
            drive(1'b0, 1'b0);
        end
        check("settle_idle", int'(busy || busy_1), 0);
        drive(1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int st, ov0, ls0, rs0, ov10, zc, cap;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);

        // Single frame, with MULT_LAT=1 instance alongside
        ov0 = ov_total; ls0 = last_total; rs0 = rise_total; ov10 = ov1_total; st = 0;
        for (int a = 0; a < 64; a++) begin
            drive(1'b1, 1'b0);
            if (a == 0) begin st = cyc; check("sel0_at_0", int'(sel[0]), 0); end
            if (a == 32) check("sel0_at_32", int'(sel[0]), 1);
        end
        for (int a = 64; a < 100; a++) begin
            drive(1'b0, 1'b0);
            if (a == 64) check("drain_zero_in", int'(zero_in), 1);
            if (a == 70) begin
                check("tw0_m37", int'(tw_exp[5:0]), 5);
                check("tw4_m3", int'(tw_exp[29:24]), 16);
            end
            if (a == 96) check("tw0_m63", int'(tw_exp[5:0]), 31);
        end
        settle();
        check("t1_first_ov_delay", rise_cyc - st, 69);
        check("t1_ov_count", ov_total - ov0, 64);
        check("t1_last_count", last_total - ls0, 1);
        check("t1_ov_runs", rise_total - rs0, 1);
        check("t1_ml1_first_ov_delay", rise1_cyc - st, 74);
        check("t1_ml1_ov_count", ov1_total - ov10, 64);

        // Back-to-back 192 samples
        ov0 = ov_total; ls0 = last_total; rs0 = rise_total; zc = 0;
        for (int a = 0; a < 192; a++) begin
            drive(1'b1, 1'b0);
            if (zero_in) zc++;
        end
        settle();
        check("t2_zero_in_count", zc, 0);
        check("t2_ov_count", ov_total - ov0, 192);
        check("t2_last_count", last_total - ls0, 3);
        check("t2_ov_runs", rise_total - rs0, 1);

        // Underrun at cnt=10, clear asserted in the same cycle
        ov0 = ov_total; ls0 = last_total;
        for (int a = 0; a < 64; a++) begin
            drive(a != 10, a == 10);
            if (a == 10) check("t3_zero_in", int'(zero_in), 1);
            if (a == 11) check("t3_err_set", int'(err_underrun), 1);
        end
        settle();
        check("t3_err_sticky", int'(err_underrun), 1);
        check("t3_ov_count", ov_total - ov0, 64);
        check("t3_last_count", last_total - ls0, 1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("t3_err_cleared", int'(err_underrun), 0);

        // Restart during drain
        ov0 = ov_total; ls0 = last_total; rs0 = rise_total;
        for (int a = 0; a < 192; a++) begin
            drive((a < 64) || (a >= 84), 1'b0);
            if (a == 84) begin
                check("t4_ready_mid", int'(in_ready), 0);
                check("t4_zero_mid", int'(zero_in), 1);
            end
            if (a == 128) check("t4_ready_bnd", int'(in_ready), 1);
        end
        settle();
        check("t4_ov_count", ov_total - ov0, 128);
        check("t4_last_count", last_total - ls0, 2);
        check("t4_ov_runs", rise_total - rs0, 2);

        // Asynchronous reset at cnt=40
        for (int a = 0; a < 41; a++) drive(1'b1, 1'b0);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", int'(in_ready), 1);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_adv", int'(adv), 0);
        check("t5_rst_sel", int'(sel), 0);
        check("t5_rst_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0);
        ov0 = ov_total; ls0 = last_total; rs0 = rise_total; st = 0; cap = 0;
        for (int a = 0; a < 64; a++) begin
            drive(1'b1, 1'b0);
            if (a == 0) st = cyc;
            if (out_valid) cap++;
        end
        check("t5_no_stale_ov", cap, 0);
        settle();
        check("t5_first_ov_delay", rise_cyc - st, 69);
        check("t5_ov_count", ov_total - ov0, 64);
        check("t5_last_count", last_total - ls0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
